// File: rtl/text_vga_pkg.sv
// Shared constants for the text-mode VGA pipeline: memory slot numbers,
// pipeline latency, default palette and sync bundle type.
package text_vga_pkg;

   localparam logic [2:0] SLOT_CHAR = 3'd0;
   localparam logic [2:0] SLOT_FONT = 3'd1;
   localparam logic [2:0] SLOT_LOAD = 3'd2;

   localparam int LATENCY = 4;

   localparam logic [8:0] PAL_ORANGE = 9'b111_101_000;
   localparam logic [8:0] PAL_CYAN   = 9'b000_111_111;
   localparam logic [8:0] PAL_NAVY   = 9'b000_000_011;

   typedef struct packed {
      logic hs;
      logic vs;
      logic en;
   } sync_t;

   // Scanline-index width for the supported glyph heights (8 or 16).
   function automatic int font_lg2(input int h);
      return (h == 8) ? 3 : 4;
   endfunction

endpackage

// File: rtl/text_cursor_blink.sv
// Cursor blink timer: counts rising edges of the (delayed) vsync and
// toggles the visible phase every BLINK_FRAMES frames.
// Ports: clk, reset (async, high), vsync in; blink_on out (1 = visible).
module text_cursor_blink
   import text_vga_pkg::*;
#(
   parameter int BLINK_FRAMES = 32
) (
   input  logic clk,
   input  logic reset,
   input  logic vsync,
   output logic blink_on
);

   localparam int CW = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CW-1:0] LAST = CW'(BLINK_FRAMES - 1);

   logic          vs_q, vs_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          phase_q, phase_d;

   always_comb begin
      vs_d    = vsync;
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (vsync && !vs_q) begin
         if (cnt_q == LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vs_q    <= 1'b0;
         cnt_q   <= '0;
         phase_q <= 1'b1;
      end else begin
         vs_q    <= vs_d;
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   assign blink_on = phase_q;

endmodule

// File: rtl/text_vga_pipeline.sv
// Text-mode VGA renderer sharing one synchronous 8-bit memory between
// character fetch (slot 0), glyph fetch (slot 1) and the CPU (slots 2-7).
// Ports: clk/reset; xpos/ypos + sync/enable in; mem_addr/mem_rdata;
// cpu_addr/cpu_rd/cpu_busy; palette and cursor config; vga_* outputs.
module text_vga_pipeline
   import text_vga_pkg::*;
#(
   parameter int COLS         = 100,
   parameter int ROWS         = 37,
   parameter int FONT_H       = 16,
   parameter int AW           = 13,
   parameter int FONT_BASE    = 3088,
   parameter int BLINK_FRAMES = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [10:0]   xpos,
   input  logic [9:0]    ypos,
   input  logic          hsync_in,
   input  logic          vsync_in,
   input  logic          enable_in,
   output logic [AW-1:0] mem_addr,
   input  logic [7:0]    mem_rdata,
   input  logic [AW-1:0] cpu_addr,
   input  logic          cpu_rd,
   output logic          cpu_busy,
   input  logic [8:0]    cfg_fg_normal,
   input  logic [8:0]    cfg_fg_high,
   input  logic [8:0]    cfg_bg,
   input  logic [6:0]    cursor_col,
   input  logic [5:0]    cursor_row,
   input  logic          cursor_en,
   output logic          vga_hsync,
   output logic          vga_vsync,
   output logic [8:0]    vga_rgb
);

   localparam int LG = font_lg2(FONT_H);
   localparam int RW = 10 - LG;

   logic [2:0]    slot;
   logic [6:0]    col;
   logic [RW-1:0] row;
   logic [LG-1:0] line;

   assign slot = xpos[2:0];
   assign col  = xpos[9:3];
   assign row  = ypos[9:LG];
   assign line = ypos[LG-1:0];

   // Cell coordinates captured in slot 0 and consumed at the slot-2 load.
   logic [6:0]    col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [LG-1:0] line_q, line_d;
   logic          off_q, off_d;
   logic          hl_pend_q, hl_pend_d;
   logic          hl_q, hl_d;
   logic [7:0]    shift_q, shift_d;
   logic [8:0]    rgb_q, rgb_d;

   sync_t [LATENCY-1:0] sync_q, sync_d;

   logic       blink_on;
   logic       blank;
   logic       cursor_hit;
   logic [7:0] glyph;

   always_comb begin
      unique case (slot)
         SLOT_CHAR: mem_addr = AW'(col) + AW'(COLS) * AW'(row);
         SLOT_FONT: mem_addr = AW'(FONT_BASE)
                             + AW'(mem_rdata[6:0]) * AW'(FONT_H)
                             + AW'(line);
         default:   mem_addr = cpu_addr;
      endcase
   end

   assign cpu_busy = cpu_rd && (slot == SLOT_CHAR || slot == SLOT_FONT);

   // Blanking wins over the cursor so off-screen cells never show it.
   always_comb begin
      blank = off_q
            || (32'(col_q) >= 32'(COLS))
            || (32'(row_q) >= 32'(ROWS));
      cursor_hit = cursor_en && blink_on
                 && (col_q == cursor_col)
                 && (32'(row_q) == 32'(cursor_row))
                 && (32'(line_q) >= 32'(FONT_H - 2));
      if (blank)
         glyph = 8'h00;
      else if (cursor_hit)
         glyph = 8'hFF;
      else
         glyph = mem_rdata;
   end

   always_comb begin
      col_d     = col_q;
      row_d     = row_q;
      line_d    = line_q;
      off_d     = off_q;
      hl_pend_d = hl_pend_q;
      hl_d      = hl_q;
      shift_d   = {shift_q[6:0], 1'b0};
      sync_d    = {sync_q[LATENCY-2:0],
                   sync_t'{hs: hsync_in, vs: vsync_in, en: enable_in}};
      unique case (slot)
         SLOT_CHAR: begin
            col_d  = col;
            row_d  = row;
            line_d = line;
            off_d  = xpos[10];
         end
         SLOT_FONT: hl_pend_d = mem_rdata[7];
         SLOT_LOAD: begin
            shift_d = glyph;
            hl_d    = hl_pend_q;
         end
         default: ;
      endcase
      // Output register: enable from stage LATENCY-2 lands with stage LATENCY-1.
      if (!sync_q[LATENCY-2].en)
         rgb_d = '0;
      else if (shift_q[7])
         rgb_d = hl_q ? cfg_fg_high : cfg_fg_normal;
      else
         rgb_d = cfg_bg;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col_q     <= '0;
         row_q     <= '0;
         line_q    <= '0;
         off_q     <= 1'b0;
         hl_pend_q <= 1'b0;
         hl_q      <= 1'b0;
         shift_q   <= '0;
         rgb_q     <= '0;
         sync_q    <= '0;
      end else begin
         col_q     <= col_d;
         row_q     <= row_d;
         line_q    <= line_d;
         off_q     <= off_d;
         hl_pend_q <= hl_pend_d;
         hl_q      <= hl_d;
         shift_q   <= shift_d;
         rgb_q     <= rgb_d;
         sync_q    <= sync_d;
      end
   end

   assign vga_hsync = sync_q[LATENCY-1].hs;
   assign vga_vsync = sync_q[LATENCY-1].vs;
   assign vga_rgb   = rgb_q;

   text_cursor_blink #(
      .BLINK_FRAMES(BLINK_FRAMES)
   ) u_blink (
      .clk     (clk),
      .reset   (reset),
      .vsync   (sync_q[LATENCY-1].vs),
      .blink_on(blink_on)
   );

endmodule

// File: tb/tb_text_vga_pipeline.sv
// Directed self-checking bench for text_vga_pipeline with a behavioural
// synchronous memory; expected pixels are hand-derived per scenario.
module tb_text_vga_pipeline;
   import text_vga_pkg::*;

   localparam logic [8:0] ORG = 9'b111_101_000;
   localparam logic [8:0] CYN = 9'b000_111_111;
   localparam logic [8:0] NVY = 9'b000_000_011;

   logic        clk = 1'b0;
   logic        reset;
   logic [10:0] xpos;
   logic [9:0]  ypos;
   logic        hsync_in, vsync_in, enable_in;
   logic [12:0] mem_addr;
   logic [7:0]  mem_rdata;
   logic [12:0] cpu_addr;
   logic        cpu_rd, cpu_busy;
   logic [8:0]  cfg_fg_normal, cfg_fg_high, cfg_bg;
   logic [6:0]  cursor_col;
   logic [5:0]  cursor_row;
   logic        cursor_en;
   logic        vga_hsync, vga_vsync;
   logic [8:0]  vga_rgb;

   logic [7:0] mem [0:8191];

   logic [8:0] cap_rgb  [0:63];
   logic       cap_busy [0:63];
   logic       cap_hs   [0:63];
   logic [7:0] cap_rd   [0:63];

   int hs_at   = -1;
   int en_off  = -1;
   int rd_from = -1;
   int n_chk   = 0;
   int n_err   = 0;

   always #5 clk = ~clk;

   always_ff @(posedge clk) mem_rdata <= mem[mem_addr];

   text_vga_pipeline dut (
      .clk          (clk),
      .reset        (reset),
      .xpos         (xpos),
      .ypos         (ypos),
      .hsync_in     (hsync_in),
      .vsync_in     (vsync_in),
      .enable_in    (enable_in),
      .mem_addr     (mem_addr),
      .mem_rdata    (mem_rdata),
      .cpu_addr     (cpu_addr),
      .cpu_rd       (cpu_rd),
      .cpu_busy     (cpu_busy),
      .cfg_fg_normal(cfg_fg_normal),
      .cfg_fg_high  (cfg_fg_high),
      .cfg_bg       (cfg_bg),
      .cursor_col   (cursor_col),
      .cursor_row   (cursor_row),
      .cursor_en    (cursor_en),
      .vga_hsync    (vga_hsync),
      .vga_vsync    (vga_vsync),
      .vga_rgb      (vga_rgb)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Drive n cycles of xpos starting at x0; after index wrap_at (if >= 0)
   // xpos restarts from 0. Captures outputs once per cycle.
   task automatic sweep(input int x0, input int n, input int wrap_at);
      for (int i = 0; i < n; i++) begin
         if (wrap_at >= 0 && i > wrap_at)
            xpos = 11'(i - wrap_at - 1);
         else
            xpos = 11'(x0 + i);
         hsync_in  = (i == hs_at);
         enable_in = (i != en_off);
         cpu_rd    = (rd_from >= 0 && i >= rd_from);
         #1;
         cap_rgb[i]  = vga_rgb;
         cap_busy[i] = cpu_busy;
         cap_hs[i]   = vga_hsync;
         cap_rd[i]   = mem_rdata;
         @(posedge clk);
         #1;
      end
      hsync_in = 1'b0;
      cpu_rd   = 1'b0;
   endtask

   task automatic vs_pulse();
      vsync_in = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      vsync_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      for (int a = 0; a < 8192; a++) mem[a] = 8'h00;
      reset = 1'b1;
      xpos = '0; ypos = '0;
      hsync_in = 0; vsync_in = 0; enable_in = 1;
      cpu_addr = '0; cpu_rd = 0;
      cfg_fg_normal = ORG; cfg_fg_high = CYN; cfg_bg = NVY;
      cursor_col = '0; cursor_row = '0; cursor_en = 0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_rgb", 32'(vga_rgb), 0);
      chk("rst_hs", 32'(vga_hsync), 0);
      chk("rst_vs", 32'(vga_vsync), 0);
      chk("rst_phase", 32'(dut.u_blink.phase_q), 1);
      chk("rst_cnt", 32'(dut.u_blink.cnt_q), 0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Glyph 'A' line 0 = 0x81, normal colour.
      mem[0] = 8'h41;
      mem[4128] = 8'h81;
      hs_at = 2; en_off = 13;
      sweep(0, 20, -1);
      hs_at = -1; en_off = -1;
      chk("a_px0", 32'(cap_rgb[4]), 32'(ORG));
      chk("a_px1", 32'(cap_rgb[5]), 32'(NVY));
      chk("a_px6", 32'(cap_rgb[10]), 32'(NVY));
      chk("a_px7", 32'(cap_rgb[11]), 32'(ORG));
      chk("a_next", 32'(cap_rgb[12]), 32'(NVY));
      chk("en_on", 32'(cap_rgb[16]), 32'(NVY));
      chk("en_off", 32'(cap_rgb[17]), 0);
      chk("hs_pre", 32'(cap_hs[5]), 0);
      chk("hs_dly", 32'(cap_hs[6]), 1);
      chk("hs_post", 32'(cap_hs[7]), 0);

      // Highlight bit selects cyan.
      mem[0] = 8'hC1;
      sweep(0, 14, -1);
      chk("hl_px0", 32'(cap_rgb[4]), 32'(CYN));
      chk("hl_px3", 32'(cap_rgb[7]), 32'(NVY));
      chk("hl_px7", 32'(cap_rgb[11]), 32'(CYN));

      // xpos wraps at slot 4 and restarts the group.
      sweep(0, 26, 12);
      chk("wrap_mid", 32'(cap_rgb[16]), 32'(NVY));
      chk("wrap_px0", 32'(cap_rgb[17]), 32'(CYN));
      chk("wrap_px1", 32'(cap_rgb[18]), 32'(NVY));
      chk("wrap_px7", 32'(cap_rgb[24]), 32'(CYN));

      // CPU access in slots 2-7.
      mem[13'h1234] = 8'h5A;
      cpu_addr = 13'h1234;
      rd_from = 7;
      sweep(0, 14, -1);
      rd_from = -1;
      chk("busy_s7", 32'(cap_busy[7]), 0);
      chk("busy_s0", 32'(cap_busy[8]), 1);
      chk("busy_s1", 32'(cap_busy[9]), 1);
      chk("busy_s2", 32'(cap_busy[10]), 0);
      chk("cpu_data", 32'(cap_rd[11]), 32'h5A);
      chk("cpu_disp", 32'(cap_rgb[4]), 32'(CYN));

      // Cursor at (2,1).
      mem[102] = 8'h41;
      mem[4141] = 8'h18;
      mem[4142] = 8'h00;
      cursor_en = 1; cursor_col = 7'd2; cursor_row = 6'd1;
      ypos = 10'd30;
      sweep(0, 30, -1);
      for (int k = 20; k < 28; k++)
         chk($sformatf("cur_px%0d", k - 20), 32'(cap_rgb[k]), 32'(ORG));
      chk("cur_left", 32'(cap_rgb[19]), 32'(NVY));
      chk("cur_right", 32'(cap_rgb[28]), 32'(NVY));
      ypos = 10'd29;
      sweep(0, 30, -1);
      chk("l13_px0", 32'(cap_rgb[20]), 32'(NVY));
      chk("l13_px3", 32'(cap_rgb[23]), 32'(ORG));
      chk("l13_px4", 32'(cap_rgb[24]), 32'(ORG));

      // Blink: 31 edges keep it visible, the 32nd hides it.
      enable_in = 0;
      xpos = '0;
      repeat (31) vs_pulse();
      repeat (6) @(posedge clk);
      #1;
      chk("blink31_cnt", 32'(dut.u_blink.cnt_q), 31);
      chk("blink31_ph", 32'(dut.u_blink.phase_q), 1);
      vs_pulse();
      repeat (6) @(posedge clk);
      #1;
      chk("blink32_cnt", 32'(dut.u_blink.cnt_q), 0);
      chk("blink32_ph", 32'(dut.u_blink.phase_q), 0);
      chk("vs_idle", 32'(vga_vsync), 0);
      ypos = 10'd30;
      sweep(0, 30, -1);
      chk("cur_hid0", 32'(cap_rgb[20]), 32'(NVY));
      chk("cur_hid7", 32'(cap_rgb[27]), 32'(NVY));

      // Reset at xpos=3 mid-frame.
      cursor_en = 0;
      ypos = '0;
      sweep(0, 15, 11);
      xpos = 11'd3;
      chk("pre_rst", 32'(vga_rgb), 32'(NVY));
      reset = 1'b1;
      #1;
      chk("mid_rst_rgb", 32'(vga_rgb), 0);
      chk("mid_rst_hs", 32'(vga_hsync), 0);
      chk("mid_rst_ph", 32'(dut.u_blink.phase_q), 1);
      chk("mid_rst_cnt", 32'(dut.u_blink.cnt_q), 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      sweep(0, 12, -1);
      chk("post_rst_px0", 32'(cap_rgb[4]), 32'(CYN));

      // Row 37 is below the screen: no text, no cursor.
      mem[3700] = 8'h41;
      mem[4143] = 8'hFF;
      cursor_en = 1; cursor_col = 7'd0; cursor_row = 6'd37;
      ypos = 10'd607;
      sweep(0, 14, -1);
      chk("row37_px0", 32'(cap_rgb[4]), 32'(NVY));
      chk("row37_px4", 32'(cap_rgb[8]), 32'(NVY));
      chk("row37_px7", 32'(cap_rgb[11]), 32'(NVY));

      // Column 100 is past the right edge.
      cursor_en = 0;
      mem[100] = 8'h41;
      ypos = '0;
      sweep(800, 14, -1);
      chk("col100_px0", 32'(cap_rgb[4]), 32'(NVY));
      chk("col100_px7", 32'(cap_rgb[11]), 32'(NVY));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
